// File: rtl/cu_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states,
// bus selects and ALU operation codes, plus small opcode classifiers.
package cu_pkg;

    typedef logic [3:0] state_t;
    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP = 4'h0;
    localparam opcode_t OP_LDI = 4'h1;
    localparam opcode_t OP_LD  = 4'h2;
    localparam opcode_t OP_ST  = 4'h3;
    localparam opcode_t OP_ADD = 4'h4;
    localparam opcode_t OP_SUB = 4'h5;
    localparam opcode_t OP_AND = 4'h6;
    localparam opcode_t OP_OR  = 4'h7;
    localparam opcode_t OP_INC = 4'h8;
    localparam opcode_t OP_DEC = 4'h9;
    localparam opcode_t OP_NOT = 4'hA;
    localparam opcode_t OP_JMP = 4'hB;
    localparam opcode_t OP_BEQ = 4'hC;
    localparam opcode_t OP_BNE = 4'hD;
    localparam opcode_t OP_BMI = 4'hE;
    localparam opcode_t OP_HLT = 4'hF;

    // F0 must stay at zero so the debug state reads 0 while reset is held.
    localparam state_t ST_F0    = 4'd0;
    localparam state_t ST_F1    = 4'd1;
    localparam state_t ST_F2    = 4'd2;
    localparam state_t ST_DEC   = 4'd3;
    localparam state_t ST_O0    = 4'd4;
    localparam state_t ST_O1    = 4'd5;
    localparam state_t ST_O2    = 4'd6;
    localparam state_t ST_M0    = 4'd7;
    localparam state_t ST_EXEC  = 4'd8;
    localparam state_t ST_HALT  = 4'd9;
    localparam state_t ST_FAULT = 4'd10;

    localparam logic [2:0] BUS1_PC   = 3'd0;
    localparam logic [1:0] BUS2_ALU  = 2'd0;
    localparam logic [1:0] BUS2_BUS1 = 2'd1;
    localparam logic [1:0] BUS2_MEM  = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd5;
    localparam logic [3:0] ALU_OR  = 4'd6;
    localparam logic [3:0] ALU_NOT = 4'd8;
    localparam logic [3:0] ALU_INC = 4'd9;
    localparam logic [3:0] ALU_DEC = 4'd10;

    function automatic logic [3:0] aluSelFor(input opcode_t op);
        logic [3:0] sel;
        sel = ALU_ADD;
        case (op)
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            OP_INC:  sel = ALU_INC;
            OP_DEC:  sel = ALU_DEC;
            OP_NOT:  sel = ALU_NOT;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

    function automatic logic isAluOp(input opcode_t op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

    function automatic logic usesRegister(input opcode_t op);
        return (op >= OP_LDI) && (op <= OP_NOT);
    endfunction

    function automatic logic isWaitState(input state_t st);
        return (st == ST_F2) || (st == ST_O2) || (st == ST_M0);
    endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// Memory wait timer: counts stalled cycles in a memory-access state and
// flags a timeout on the stalled cycle at which the count reaches WAIT_MAX-1.
module cu_wait_timer #(
    parameter int WAIT_MAX = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_active,
    input  logic i_ready,
    output logic o_timeout
);

    localparam int CW = $clog2(WAIT_MAX) + 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_countInc;
    logic          w_stall;

    assign w_stall    = i_active && !i_ready;
    assign w_countInc = r_count + CW'(1);
    assign o_timeout  = w_stall && (w_countInc == LAST);

    // Clearing wins over counting so a back-to-back O2->M0 hand-off restarts at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (w_stall) begin
            r_count <= w_countInc;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: fetch / decode / operand / memory / execute FSM.
// Define CU_COND_BRANCH_EN to enable BEQ/BNE/BMI; otherwise they are two-byte NOPs.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int NREG     = 2,
    parameter int WAIT_MAX = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [7:0]      ir,
    input  logic [3:0]      ccr,
    input  logic            mem_ready,
    output logic            ir_load,
    output logic            mar_load,
    output logic            pc_load,
    output logic            pc_inc,
    output logic [NREG-1:0] reg_load,
    output logic [2:0]      bus1_sel,
    output logic [1:0]      bus2_sel,
    output logic [3:0]      alu_sel,
    output logic            ccr_load,
    output logic            write,
    output logic            mem_req,
    output logic            halted,
    output logic            fault,
    output logic [3:0]      state_o
);

    localparam logic [2:0] NREG_L = 3'(NREG);

    state_t          r_state;
    state_t          w_nextState;
    opcode_t         w_op;
    logic [1:0]      w_r;
    logic [NREG-1:0] w_regOneHot;
    logic [2:0]      w_regBus1;
    logic            w_regValid;
    logic            w_branchTaken;
    logic            w_waitActive;
    logic            w_waitClear;
    logic            w_timeout;
    logic            w_unusedBits;

    assign w_op       = ir[7:4];
    assign w_r        = ir[1:0];
    assign w_regValid = ({1'b0, w_r} < NREG_L);
    assign w_regBus1  = {1'b0, w_r} + 3'd1;

    always_comb begin
        for (int k = 0; k < NREG; k++) begin
            w_regOneHot[k] = (w_r == 2'(k));
        end
    end

    // ccr is {N,Z,V,C}; only N and Z steer branches.
    always_comb begin
        w_branchTaken = 1'b0;
        case (w_op)
            OP_JMP:  w_branchTaken = 1'b1;
`ifdef CU_COND_BRANCH_EN
            OP_BEQ:  w_branchTaken = ccr[2];
            OP_BNE:  w_branchTaken = !ccr[2];
            OP_BMI:  w_branchTaken = ccr[3];
`endif
            default: w_branchTaken = 1'b0;
        endcase
    end

`ifdef CU_COND_BRANCH_EN
    assign w_unusedBits = ^{ir[3:2], ccr[1:0]};
`else
    assign w_unusedBits = ^{ir[3:2], ccr};
`endif

    assign w_waitActive = isWaitState(r_state);
    assign w_waitClear  = isWaitState(w_nextState) && (w_nextState != r_state);

    cu_wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_waitTimer (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_waitClear),
        .i_active (w_waitActive),
        .i_ready  (mem_ready),
        .o_timeout(w_timeout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_F0;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_F0: w_nextState = ST_F1;
            ST_F1: w_nextState = ST_F2;
            ST_F2: begin
                if (mem_ready) begin
                    w_nextState = ST_DEC;
                end else if (w_timeout) begin
                    w_nextState = ST_FAULT;
                end
            end
            // An out-of-range register index must never reach a datapath load.
            ST_DEC: begin
                if (w_op == OP_NOP) begin
                    w_nextState = ST_F0;
                end else if (w_op == OP_HLT) begin
                    w_nextState = ST_HALT;
                end else if (usesRegister(w_op) && !w_regValid) begin
                    w_nextState = ST_FAULT;
                end else if (isAluOp(w_op)) begin
                    w_nextState = ST_EXEC;
                end else begin
                    w_nextState = ST_O0;
                end
            end
            ST_O0: w_nextState = ST_O1;
            ST_O1: w_nextState = ST_O2;
            ST_O2: begin
                if (mem_ready) begin
                    w_nextState = ((w_op == OP_LD) || (w_op == OP_ST)) ? ST_M0 : ST_F0;
                end else if (w_timeout) begin
                    w_nextState = ST_FAULT;
                end
            end
            ST_M0: begin
                if (mem_ready) begin
                    w_nextState = ST_F0;
                end else if (w_timeout) begin
                    w_nextState = ST_FAULT;
                end
            end
            ST_EXEC:  w_nextState = ST_F0;
            ST_HALT:  w_nextState = ST_HALT;
            ST_FAULT: w_nextState = ST_FAULT;
            default:  w_nextState = ST_FAULT;
        endcase
    end

    // Reset forces every control line low even though F0 normally drives mar_load.
    always_comb begin
        ir_load  = 1'b0;
        mar_load = 1'b0;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        reg_load = '0;
        bus1_sel = BUS1_PC;
        bus2_sel = BUS2_ALU;
        alu_sel  = ALU_ADD;
        ccr_load = 1'b0;
        write    = 1'b0;
        mem_req  = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_F0, ST_O0: mar_load = 1'b1;
                ST_F1, ST_O1: pc_inc = 1'b1;
                ST_F2: begin
                    mem_req  = 1'b1;
                    bus2_sel = BUS2_MEM;
                    ir_load  = mem_ready;
                end
                ST_O2: begin
                    mem_req  = 1'b1;
                    bus2_sel = BUS2_MEM;
                    if (mem_ready) begin
                        case (w_op)
                            OP_LDI:       reg_load = w_regOneHot;
                            OP_LD, OP_ST: mar_load = 1'b1;
                            default:      pc_load  = w_branchTaken;
                        endcase
                    end
                end
                ST_M0: begin
                    mem_req = 1'b1;
                    if (w_op == OP_ST) begin
                        bus1_sel = w_regBus1;
                        bus2_sel = BUS2_BUS1;
                        write    = 1'b1;
                    end else begin
                        bus2_sel = BUS2_MEM;
                        reg_load = mem_ready ? w_regOneHot : '0;
                    end
                end
                ST_EXEC: begin
                    bus1_sel = w_regBus1;
                    bus2_sel = BUS2_ALU;
                    reg_load = w_regOneHot;
                    ccr_load = 1'b1;
                    alu_sel  = aluSelFor(w_op);
                end
                ST_HALT:  halted = 1'b1;
                ST_FAULT: fault  = 1'b1;
                default: begin
                end
            endcase
        end
    end

    assign state_o = r_state;

endmodule
